// File: rtl/ahb_slave_if.sv
// AHB-Lite slave front end: turns accepted AHB transfers into a single local
// access handshake and returns OKAY, or a two-cycle ERROR on misalignment, local error or timeout.
module ahb_slave_if #(
   parameter int AHB_ADDR_WIDTH   = 32,
   parameter int AHB_DATA_WIDTH   = 32,
   parameter int AHB_WAIT_TIMEOUT = 6
) (
   input  logic                      ahb_clk_in,
   input  logic                      ahb_rstn_in,
   input  logic                      ahb_sel_in,
   input  logic [AHB_ADDR_WIDTH-1:0] ahb_addr_in,
   input  logic [1:0]                ahb_trans_in,
   input  logic                      ahb_write_in,
   input  logic [2:0]                ahb_size_in,
   input  logic [2:0]                ahb_burst_in,
   input  logic [AHB_DATA_WIDTH-1:0] ahb_wdata_in,
   input  logic                      ahb_ready_in,
   output logic                      ahb_readyout_out,
   output logic                      ahb_resp_out,
   output logic [AHB_DATA_WIDTH-1:0] ahb_rdata_out,
   output logic                      other_valid_out,
   output logic [AHB_ADDR_WIDTH-1:0] other_addr_out,
   output logic                      other_write_out,
   output logic [2:0]                other_size_out,
   output logic [AHB_DATA_WIDTH-1:0] other_wdata_out,
   input  logic                      other_ready_in,
   input  logic                      other_error_in,
   input  logic [AHB_DATA_WIDTH-1:0] other_rdata_in
);

   localparam int CW = $clog2(AHB_WAIT_TIMEOUT + 1);

   typedef enum logic [3:0] {
      IDLE   = 4'b0001,
      ACCESS = 4'b0010,
      ERR1   = 4'b0100,
      ERR2   = 4'b1000
   } state_e;

   state_e                    state_q, state_d;
   logic                      readyout_q, readyout_d;
   logic                      resp_q, resp_d;
   logic [AHB_DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                      valid_q, valid_d;
   logic [AHB_ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                      write_q, write_d;
   logic [2:0]                size_q, size_d;
   logic [CW-1:0]             wcnt_q, wcnt_d;

   logic                      accept;
   logic                      bad_xfer;
   logic [AHB_ADDR_WIDTH-1:0] align_mask;

   // burst type and SEQ/NONSEQ distinction carry no meaning for a single-beat slave
   logic unused_ok;
   assign unused_ok = ^{ahb_burst_in, ahb_trans_in[0]};

   assign accept     = (state_q == IDLE) && ahb_sel_in && ahb_ready_in && ahb_trans_in[1];
   assign align_mask = (AHB_ADDR_WIDTH'(1) << ahb_size_in) - AHB_ADDR_WIDTH'(1);
   assign bad_xfer   = ((32'd8 << ahb_size_in) > 32'(AHB_DATA_WIDTH)) ||
                       (|(ahb_addr_in & align_mask));

   always_comb begin
      state_d    = state_q;
      readyout_d = readyout_q;
      resp_d     = resp_q;
      rdata_d    = rdata_q;
      valid_d    = valid_q;
      addr_d     = addr_q;
      write_d    = write_q;
      size_d     = size_q;
      wcnt_d     = wcnt_q;
      unique case (state_q)
         IDLE: begin
            readyout_d = 1'b1;
            resp_d     = 1'b0;
            if (accept) begin
               addr_d     = ahb_addr_in;
               write_d    = ahb_write_in;
               size_d     = ahb_size_in;
               readyout_d = 1'b0;
               if (bad_xfer) begin
                  state_d = ERR1;
                  resp_d  = 1'b1;
                  rdata_d = '0;
               end else begin
                  state_d = ACCESS;
                  valid_d = 1'b1;
                  wcnt_d  = '0;
               end
            end
         end
         ACCESS: begin
            if (other_ready_in) begin
               valid_d = 1'b0;
               if (other_error_in) begin
                  state_d = ERR1;
                  resp_d  = 1'b1;
                  rdata_d = '0;
               end else begin
                  state_d    = IDLE;
                  readyout_d = 1'b1;
                  resp_d     = 1'b0;
                  rdata_d    = write_q ? '0 : other_rdata_in;
               end
            end else begin
               wcnt_d = wcnt_q + CW'(1);
               // last permitted wait cycle: abandon the access
               if (wcnt_q == CW'(AHB_WAIT_TIMEOUT - 1)) begin
                  state_d = ERR1;
                  valid_d = 1'b0;
                  resp_d  = 1'b1;
                  rdata_d = '0;
               end
            end
         end
         ERR1: begin
            state_d    = ERR2;
            readyout_d = 1'b1;
            resp_d     = 1'b1;
         end
         ERR2: begin
            state_d    = IDLE;
            readyout_d = 1'b1;
            resp_d     = 1'b0;
         end
         default: begin
            state_d    = IDLE;
            readyout_d = 1'b1;
            resp_d     = 1'b0;
            valid_d    = 1'b0;
         end
      endcase
   end

   always_ff @(posedge ahb_clk_in or negedge ahb_rstn_in) begin
      if (!ahb_rstn_in) begin
         state_q    <= IDLE;
         readyout_q <= 1'b1;
         resp_q     <= 1'b0;
         rdata_q    <= '0;
         valid_q    <= 1'b0;
         addr_q     <= '0;
         write_q    <= 1'b0;
         size_q     <= '0;
         wcnt_q     <= '0;
      end else begin
         state_q    <= state_d;
         readyout_q <= readyout_d;
         resp_q     <= resp_d;
         rdata_q    <= rdata_d;
         valid_q    <= valid_d;
         addr_q     <= addr_d;
         write_q    <= write_d;
         size_q     <= size_d;
         wcnt_q     <= wcnt_d;
      end
   end

   assign ahb_readyout_out = readyout_q;
   assign ahb_resp_out     = resp_q;
   assign ahb_rdata_out    = rdata_q;
   assign other_valid_out  = valid_q;
   assign other_addr_out   = addr_q;
   assign other_write_out  = write_q;
   assign other_size_out   = size_q;
   assign other_wdata_out  = ahb_wdata_in;

endmodule

// File: tb/tb_ahb_slave_if.sv
// Directed bench for ahb_slave_if: expected responses go into a scoreboard
// queue when a transfer is issued and are popped when the data phase completes.
module tb_ahb_slave_if;

   logic        ahb_clk_in = 1'b0;
   logic        ahb_rstn_in;
   logic        ahb_sel_in;
   logic [31:0] ahb_addr_in;
   logic [1:0]  ahb_trans_in;
   logic        ahb_write_in;
   logic [2:0]  ahb_size_in;
   logic [2:0]  ahb_burst_in;
   logic [31:0] ahb_wdata_in;
   logic        ahb_ready_in;
   logic        ahb_readyout_out;
   logic        ahb_resp_out;
   logic [31:0] ahb_rdata_out;
   logic        other_valid_out;
   logic [31:0] other_addr_out;
   logic        other_write_out;
   logic [2:0]  other_size_out;
   logic [31:0] other_wdata_out;
   logic        other_ready_in;
   logic        other_error_in;
   logic [31:0] other_rdata_in;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic        resp;
      logic [31:0] rdata;
      int          vcyc;
   } exp_t;
   exp_t sb[$];

   ahb_slave_if #(.AHB_ADDR_WIDTH(32), .AHB_DATA_WIDTH(32), .AHB_WAIT_TIMEOUT(6)) dut (
      .ahb_clk_in(ahb_clk_in), .ahb_rstn_in(ahb_rstn_in),
      .ahb_sel_in(ahb_sel_in), .ahb_addr_in(ahb_addr_in), .ahb_trans_in(ahb_trans_in),
      .ahb_write_in(ahb_write_in), .ahb_size_in(ahb_size_in), .ahb_burst_in(ahb_burst_in),
      .ahb_wdata_in(ahb_wdata_in), .ahb_ready_in(ahb_ready_in),
      .ahb_readyout_out(ahb_readyout_out), .ahb_resp_out(ahb_resp_out),
      .ahb_rdata_out(ahb_rdata_out), .other_valid_out(other_valid_out),
      .other_addr_out(other_addr_out), .other_write_out(other_write_out),
      .other_size_out(other_size_out), .other_wdata_out(other_wdata_out),
      .other_ready_in(other_ready_in), .other_error_in(other_error_in),
      .other_rdata_in(other_rdata_in)
   );

   always #5 ahb_clk_in = ~ahb_clk_in;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One isolated transfer; rdy_at = ACCESS cycle index to signal local completion, -1 = never.
   task automatic xfer(input string tag, input logic [31:0] a, input logic w, input logic [2:0] sz,
                       input logic [31:0] wd, input int rdy_at, input logic err, input logic [31:0] rd);
      exp_t e, got;
      logic bad, tmo;
      int   vc, lowc, idx;
      bit   done;
      bad     = ((32'd8 << sz) > 32'd32) || ((a & ((32'd1 << sz) - 32'd1)) != 32'd0);
      tmo     = !bad && (rdy_at < 0 || rdy_at >= 6);
      e.vcyc  = bad ? 0 : (tmo ? 6 : rdy_at + 1);
      e.resp  = bad | tmo | (err & !bad);
      e.rdata = (e.resp | w) ? 32'd0 : rd;
      sb.push_back(e);
      ahb_sel_in = 1'b1; ahb_trans_in = 2'd2; ahb_addr_in = a; ahb_write_in = w; ahb_size_in = sz;
      @(negedge ahb_clk_in);
      ahb_sel_in = 1'b0; ahb_trans_in = 2'd0; ahb_wdata_in = wd;
      vc = 0; lowc = 0; idx = 0; done = 0;
      for (int i = 0; i < 20 && !done; i++) begin
         if (ahb_readyout_out) done = 1;
         else begin
            lowc++;
            if (other_valid_out) begin
               vc++;
               if (idx == 0) begin
                  chk({tag, "_addr"}, other_addr_out, a);
                  chk({tag, "_write"}, {31'd0, other_write_out}, {31'd0, w});
                  chk({tag, "_wdata"}, other_wdata_out, wd);
               end
               other_ready_in = (idx == rdy_at); other_error_in = err; other_rdata_in = rd;
               idx++;
            end else other_ready_in = 1'b0;
            @(negedge ahb_clk_in);
         end
      end
      other_ready_in = 1'b0; other_error_in = 1'b0;
      if (!done) chk({tag, "_completion_timeout"}, 32'd0, 32'd1);
      got = sb.pop_front();
      chk({tag, "_resp"}, {31'd0, ahb_resp_out}, {31'd0, got.resp});
      chk({tag, "_rdata"}, ahb_rdata_out, got.rdata);
      chk({tag, "_valid_cycles"}, vc, got.vcyc);
      chk({tag, "_wait_cycles"}, lowc, got.vcyc + (got.resp ? 1 : 0));
      if (got.resp) begin
         @(negedge ahb_clk_in);
         chk({tag, "_post_err_ready"}, {31'd0, ahb_readyout_out}, 32'd1);
         chk({tag, "_post_err_resp"}, {31'd0, ahb_resp_out}, 32'd0);
      end
   endtask

   initial begin
      exp_t e, got;
      int   nv;
      ahb_rstn_in = 1'b1; ahb_sel_in = 1'b0; ahb_addr_in = '0; ahb_trans_in = 2'd0;
      ahb_write_in = 1'b0; ahb_size_in = 3'd0; ahb_burst_in = 3'd0; ahb_wdata_in = '0;
      ahb_ready_in = 1'b1; other_ready_in = 1'b0; other_error_in = 1'b0; other_rdata_in = '0;
      #1 ahb_rstn_in = 1'b0;
      #2;
      chk("rst_readyout", {31'd0, ahb_readyout_out}, 32'd1);
      chk("rst_resp", {31'd0, ahb_resp_out}, 32'd0);
      chk("rst_rdata", ahb_rdata_out, 32'd0);
      chk("rst_valid", {31'd0, other_valid_out}, 32'd0);
      chk("rst_addr", other_addr_out, 32'd0);
      chk("rst_write", {31'd0, other_write_out}, 32'd0);
      chk("rst_size", {29'd0, other_size_out}, 32'd0);
      repeat (2) @(negedge ahb_clk_in);
      ahb_rstn_in = 1'b1;
      @(negedge ahb_clk_in);

      // IDLE and BUSY transfers are zero-wait OKAY with no local access
      ahb_sel_in = 1'b1; ahb_trans_in = 2'd0; ahb_addr_in = 32'h40; ahb_size_in = 3'd2;
      @(negedge ahb_clk_in);
      chk("idle_ready", {31'd0, ahb_readyout_out}, 32'd1);
      chk("idle_valid", {31'd0, other_valid_out}, 32'd0);
      ahb_trans_in = 2'd1;
      @(negedge ahb_clk_in);
      chk("busy_ready", {31'd0, ahb_readyout_out}, 32'd1);
      chk("busy_resp", {31'd0, ahb_resp_out}, 32'd0);
      chk("busy_valid", {31'd0, other_valid_out}, 32'd0);
      ahb_sel_in = 1'b0; ahb_trans_in = 2'd0;
      @(negedge ahb_clk_in);

      xfer("read100", 32'h100, 1'b0, 3'd2, 32'h0, 1, 1'b0, 32'hDEADBEEF);
      xfer("read_half", 32'h6, 1'b0, 3'd1, 32'h0, 0, 1'b0, 32'h0000A5A5);
      xfer("size_bad", 32'h0, 1'b0, 3'd3, 32'h0, 0, 1'b0, 32'h12345678);
      xfer("timeout", 32'h20, 1'b0, 3'd2, 32'h0, -1, 1'b0, 32'h55);
      xfer("late_ok", 32'h24, 1'b0, 3'd2, 32'h0, 5, 1'b0, 32'h600D);
      xfer("local_err", 32'h8, 1'b1, 3'd2, 32'h55, 0, 1'b1, 32'h1234);

      // misaligned word, with a new address phase presented during ERR2
      ahb_sel_in = 1'b1; ahb_trans_in = 2'd2; ahb_addr_in = 32'h102; ahb_write_in = 1'b0; ahb_size_in = 3'd2;
      @(negedge ahb_clk_in);
      ahb_sel_in = 1'b0; ahb_trans_in = 2'd0;
      chk("mis_err1_ready", {31'd0, ahb_readyout_out}, 32'd0);
      chk("mis_err1_resp", {31'd0, ahb_resp_out}, 32'd1);
      chk("mis_err1_valid", {31'd0, other_valid_out}, 32'd0);
      @(negedge ahb_clk_in);
      chk("mis_err2_ready", {31'd0, ahb_readyout_out}, 32'd1);
      chk("mis_err2_resp", {31'd0, ahb_resp_out}, 32'd1);
      ahb_sel_in = 1'b1; ahb_trans_in = 2'd2; ahb_addr_in = 32'h200;
      @(negedge ahb_clk_in);
      ahb_sel_in = 1'b0; ahb_trans_in = 2'd0;
      chk("mis_idle_ready", {31'd0, ahb_readyout_out}, 32'd1);
      chk("mis_idle_resp", {31'd0, ahb_resp_out}, 32'd0);
      chk("err2_addr_ignored", {31'd0, other_valid_out}, 32'd0);
      @(negedge ahb_clk_in);
      chk("err2_addr_ignored2", {31'd0, other_valid_out}, 32'd0);

      // back-to-back: write 0x0 then read 0x4, both ready in first ACCESS cycle
      ahb_sel_in = 1'b1; ahb_trans_in = 2'd2; ahb_addr_in = 32'h0; ahb_write_in = 1'b1; ahb_size_in = 3'd2;
      e.resp = 1'b0; e.rdata = 32'h0; e.vcyc = 1; sb.push_back(e);
      @(negedge ahb_clk_in);
      ahb_wdata_in = 32'h11;
      ahb_addr_in = 32'h4; ahb_write_in = 1'b0;
      #1;
      chk("b2b_wr_valid", {31'd0, other_valid_out}, 32'd1);
      chk("b2b_wr_write", {31'd0, other_write_out}, 32'd1);
      chk("b2b_wr_wdata", other_wdata_out, 32'h11);
      other_ready_in = 1'b1; other_rdata_in = 32'hFFFF_FFFF;
      @(negedge ahb_clk_in);
      other_ready_in = 1'b0;
      got = sb.pop_front();
      chk("b2b_wr_ready", {31'd0, ahb_readyout_out}, 32'd1);
      chk("b2b_wr_resp", {31'd0, ahb_resp_out}, {31'd0, got.resp});
      e.resp = 1'b0; e.rdata = 32'hCAFE0004; e.vcyc = 1; sb.push_back(e);
      @(negedge ahb_clk_in);
      ahb_sel_in = 1'b0; ahb_trans_in = 2'd0;
      chk("b2b_rd_issued", {31'd0, other_valid_out}, 32'd1);
      chk("b2b_rd_addr", other_addr_out, 32'h4);
      chk("b2b_rd_write", {31'd0, other_write_out}, 32'd0);
      other_ready_in = 1'b1; other_rdata_in = 32'hCAFE0004;
      @(negedge ahb_clk_in);
      other_ready_in = 1'b0;
      got = sb.pop_front();
      chk("b2b_rd_ready", {31'd0, ahb_readyout_out}, 32'd1);
      chk("b2b_rd_resp", {31'd0, ahb_resp_out}, {31'd0, got.resp});
      chk("b2b_rd_rdata", ahb_rdata_out, got.rdata);

      // asynchronous reset in the middle of an ACCESS
      ahb_sel_in = 1'b1; ahb_trans_in = 2'd2; ahb_addr_in = 32'h30; ahb_write_in = 1'b1; ahb_size_in = 3'd2;
      @(negedge ahb_clk_in);
      ahb_sel_in = 1'b0; ahb_trans_in = 2'd0;
      chk("rstmid_in_access", {31'd0, other_valid_out}, 32'd1);
      #2 ahb_rstn_in = 1'b0;
      #1;
      chk("rstmid_valid", {31'd0, other_valid_out}, 32'd0);
      chk("rstmid_ready", {31'd0, ahb_readyout_out}, 32'd1);
      chk("rstmid_addr", other_addr_out, 32'd0);
      @(negedge ahb_clk_in);
      #2 ahb_rstn_in = 1'b1;
      nv = 0;
      repeat (8) begin
         @(negedge ahb_clk_in);
         if (other_valid_out) nv++;
      end
      chk("rstmid_no_reissue", nv, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
